ltc_frame_aligner: RTL and testbench

LTC_FRAME_ALIGNER -- requirements
Module: ltc_frame_aligner

---
 rtl/ltc_pkg.sv | 16 +
 rtl/ltc_frame_aligner_if.sv | 25 ++
 rtl/ltc_word_interleave.sv | 17 +
 rtl/ltc_frame_aligner.sv | 130 +++++++++++++
 tb/tb_ltc_frame_aligner.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/ltc_pkg.sv
// rtl/ltc_pkg.sv - shared defaults and state encoding for the LTC frame aligner
package ltc_pkg;

  localparam logic [7:0] DEF_FRAME_PATTERN = 8'hF0;
  localparam int         DEF_LOCK_COUNT    = 8;
  localparam int         DEF_MISS_LIMIT    = 4;
  localparam int         DEF_SLIP_WAIT     = 4;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOCKED = 2'd3
  } ltc_state_e;

endpackage

// File: rtl/ltc_frame_aligner_if.sv
// rtl/ltc_frame_aligner_if.sv - deserializer lanes in, alignment status and samples out
interface ltc_frame_aligner_if;

  logic [7:0]  frame_word;
  logic [7:0]  lane_a;
  logic [7:0]  lane_b;
  logic        bitslip;
  logic        aligned;
  logic [15:0] sample;
  logic        sample_valid;
  logic [2:0]  slip_pos;
  logic        lock_lost;

  // master drives the ISERDES side, slave is the aligner
  modport master (
    output frame_word, lane_a, lane_b,
    input  bitslip, aligned, sample, sample_valid, slip_pos, lock_lost
  );

  modport slave (
    input  frame_word, lane_a, lane_b,
    output bitslip, aligned, sample, sample_valid, slip_pos, lock_lost
  );

endinterface

// File: rtl/ltc_word_interleave.sv
// rtl/ltc_word_interleave.sv - merges two MSB-first 8-bit lanes into one 16-bit sample
module ltc_word_interleave (
  input  logic [7:0]  lane_a,
  input  logic [7:0]  lane_b,
  output logic [15:0] word
);

  // lane A carries the odd (upper) bit of each pair, lane B the even bit
  always_comb begin
    word = '0;
    for (int k = 0; k < 8; k++) begin
      word[15 - 2*k] = lane_a[7 - k];
      word[14 - 2*k] = lane_b[7 - k];
    end
  end

endmodule

// File: rtl/ltc_frame_aligner.sv
// rtl/ltc_frame_aligner.sv - bitslip search and lock tracking on the frame-clock lane
module ltc_frame_aligner
  import ltc_pkg::*;
#(
  parameter logic [7:0] FRAME_PATTERN = DEF_FRAME_PATTERN,
  parameter int         LOCK_COUNT    = DEF_LOCK_COUNT,
  parameter int         MISS_LIMIT    = DEF_MISS_LIMIT,
  parameter int         SLIP_WAIT     = DEF_SLIP_WAIT
) (
  input  logic               sample_clk,
  input  logic               sample_rst,
  ltc_frame_aligner_if.slave bus
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int XW = $clog2(MISS_LIMIT + 1);
  localparam int WW = $clog2(SLIP_WAIT + 1);

  localparam logic [MW-1:0] LOCK_MAX = MW'(LOCK_COUNT);
  localparam logic [XW-1:0] MISS_MAX = XW'(MISS_LIMIT);
  localparam logic [WW-1:0] WAIT_MAX = WW'(SLIP_WAIT);
  localparam logic [MW-1:0] M_ONE    = MW'(1);
  localparam logic [XW-1:0] X_ONE    = XW'(1);
  localparam logic [WW-1:0] W_ONE    = WW'(1);

  ltc_state_e    state_q, state_d;
  logic [MW-1:0] match_cnt_q, match_cnt_d;
  logic [XW-1:0] miss_cnt_q, miss_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [2:0]    slip_pos_q, slip_pos_d;
  logic          lock_lost_q, lock_lost_d;
  logic [15:0]   sample_q;
  logic          sample_valid_q;
  logic [15:0]   interleaved;
  logic          frame_match;

  assign frame_match = (bus.frame_word == FRAME_PATTERN);

  ltc_word_interleave u_interleave (
    .lane_a (bus.lane_a),
    .lane_b (bus.lane_b),
    .word   (interleaved)
  );

  // state, counters and sticky flag
  always_ff @(posedge sample_clk or posedge sample_rst) begin
    if (sample_rst) begin
      state_q     <= ST_SEARCH;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      slip_pos_q  <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      slip_pos_q  <= slip_pos_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  // next-state: search for the pattern, slip on mismatch, hold lock until repeated misses
  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    slip_pos_d  = slip_pos_q;
    lock_lost_d = lock_lost_q;
    case (state_q)
      ST_SEARCH: begin
        if (frame_match) begin
          if (match_cnt_q != LOCK_MAX) match_cnt_d = match_cnt_q + M_ONE;
          if (match_cnt_d == LOCK_MAX) state_d = ST_LOCKED;
        end else begin
          match_cnt_d = '0;
          slip_pos_d  = slip_pos_q + 3'd1;
          state_d     = ST_SLIP;
        end
      end
      ST_SLIP: begin
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if ((wait_cnt_q + W_ONE) == WAIT_MAX) begin
          wait_cnt_d  = '0;
          match_cnt_d = '0;
          state_d     = ST_SEARCH;
        end else begin
          wait_cnt_d = wait_cnt_q + W_ONE;
        end
      end
      ST_LOCKED: begin
        if (frame_match) begin
          miss_cnt_d = '0;
        end else if ((miss_cnt_q + X_ONE) == MISS_MAX) begin
          miss_cnt_d  = '0;
          match_cnt_d = '0;
          lock_lost_d = 1'b1;
          state_d     = ST_SEARCH;
        end else begin
          miss_cnt_d = miss_cnt_q + X_ONE;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  // sample path runs every cycle; validity follows the lock state of the same cycle
  always_ff @(posedge sample_clk or posedge sample_rst) begin
    if (sample_rst) begin
      sample_q       <= 16'h0000;
      sample_valid_q <= 1'b0;
    end else begin
      sample_q       <= interleaved;
      sample_valid_q <= (state_q == ST_LOCKED);
    end
  end

  assign bus.bitslip      = (state_q == ST_SLIP);
  assign bus.aligned      = (state_q == ST_LOCKED);
  assign bus.sample       = sample_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.slip_pos     = slip_pos_q;
  assign bus.lock_lost    = lock_lost_q;

endmodule

// File: tb/tb_ltc_frame_aligner.sv
// tb/tb_ltc_frame_aligner.sv - directed bench for the LTC frame aligner
module tb_ltc_frame_aligner;

  logic sample_clk = 1'b0;
  logic sample_rst = 1'b0;

  ltc_frame_aligner_if bus ();

  ltc_frame_aligner dut (
    .sample_clk (sample_clk),
    .sample_rst (sample_rst),
    .bus        (bus)
  );

  always #5 sample_clk = ~sample_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int slip_cnt;
  int last_slip_cyc;
  int min_gap;
  int t_start;
  bit skip_next_slip;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one cycle; ISERDES model rotates frame_word left on each observed bitslip
  task automatic tick();
    @(negedge sample_clk);
    cyc++;
    if (bus.bitslip === 1'b1) begin
      if (cyc - last_slip_cyc < min_gap) min_gap = cyc - last_slip_cyc;
      last_slip_cyc = cyc;
      slip_cnt++;
      if (skip_next_slip) skip_next_slip = 1'b0;
      else bus.frame_word = {bus.frame_word[6:0], bus.frame_word[7]};
    end
  endtask

  task automatic clear_stats();
    slip_cnt       = 0;
    last_slip_cyc  = -1000;
    min_gap        = 1000;
    skip_next_slip = 1'b0;
  endtask

  task automatic do_reset(input logic [7:0] start_word);
    sample_rst     = 1'b1;
    bus.frame_word = start_word;
    bus.lane_a     = 8'h00;
    bus.lane_b     = 8'h00;
    repeat (2) tick();
    sample_rst = 1'b0;
    clear_stats();
    t_start = cyc;
  endtask

  task automatic run_until_aligned(input string tag, input int budget);
    for (int i = 0; i < budget && bus.aligned !== 1'b1; i++) tick();
    chk({tag, " lock"}, bus.aligned, 1);
  endtask

  initial begin
    bus.frame_word = 8'hF0;
    bus.lane_a     = 8'h00;
    bus.lane_b     = 8'h00;
    clear_stats();
    #1 sample_rst = 1'b1;
    #1;
    chk("rst bitslip", bus.bitslip, 0);
    chk("rst aligned", bus.aligned, 0);
    chk("rst sample", bus.sample, 16'h0000);
    chk("rst valid", bus.sample_valid, 0);
    chk("rst slip_pos", bus.slip_pos, 0);
    chk("rst lock_lost", bus.lock_lost, 0);

    // scenario 1: aligned from the start
    do_reset(8'hF0);
    repeat (7) tick();
    chk("s1 aligned after 7", bus.aligned, 0);
    tick();
    chk("s1 aligned after 8", bus.aligned, 1);
    chk("s1 slips", slip_cnt, 0);
    chk("s1 slip_pos", bus.slip_pos, 0);
    chk("s1 lock_lost", bus.lock_lost, 0);

    // scenario 4: interleave while locked
    bus.lane_a = 8'h02; bus.lane_b = 8'h03;
    tick();
    chk("s4 sample 02/03", bus.sample, 16'h000D);
    chk("s4 valid", bus.sample_valid, 1);
    bus.lane_a = 8'hA5; bus.lane_b = 8'h3C;
    tick();
    chk("s4 sample A5/3C", bus.sample, 16'h8D72);
    bus.lane_a = 8'hFF; bus.lane_b = 8'h00;
    tick();
    chk("s4 sample FF/00", bus.sample, 16'hAAAA);

    // scenario 5: miss tolerance, loss and relock
    bus.frame_word = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s5 hold on miss", bus.aligned, 1);
    end
    bus.frame_word = 8'hF0;
    tick();
    chk("s5 hold after match", bus.aligned, 1);
    bus.frame_word = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s5 hold 3 misses", bus.aligned, 1);
    end
    tick();
    chk("s5 lost aligned", bus.aligned, 0);
    chk("s5 lost flag", bus.lock_lost, 1);
    chk("s5 valid lag", bus.sample_valid, 1);
    bus.frame_word = 8'hF0;
    tick();
    chk("s5 valid drop", bus.sample_valid, 0);
    run_until_aligned("s5 relock", 20);
    chk("s5 sticky", bus.lock_lost, 1);
    chk("s5 slips", slip_cnt, 0);

    // scenario 6: reset during WAIT
    bus.lane_a = 8'hA5; bus.lane_b = 8'h3C;
    bus.frame_word = 8'h78;
    repeat (4) tick();
    chk("s6 dropped", bus.aligned, 0);
    tick();
    chk("s6 slip seen", slip_cnt, 1);
    tick();
    chk("s6 slip_pos", bus.slip_pos, 1);
    chk("s6 sample pre", bus.sample, 16'h8D72);
    #2 sample_rst = 1'b1;
    #1;
    chk("s6 rst bitslip", bus.bitslip, 0);
    chk("s6 rst aligned", bus.aligned, 0);
    chk("s6 rst sample", bus.sample, 16'h0000);
    chk("s6 rst valid", bus.sample_valid, 0);
    chk("s6 rst slip_pos", bus.slip_pos, 0);
    chk("s6 rst lock_lost", bus.lock_lost, 0);
    repeat (3) tick();
    chk("s6 no slip in rst", slip_cnt, 1);
    sample_rst = 1'b0;
    clear_stats();
    bus.frame_word = 8'hF0;
    repeat (12) tick();
    chk("s6 no slip after", slip_cnt, 0);
    chk("s6 relock", bus.aligned, 1);

    // scenario 2: one slip needed
    do_reset(8'h78);
    run_until_aligned("s2", 60);
    chk("s2 latency", cyc - t_start, 14);
    chk("s2 slips", slip_cnt, 1);
    chk("s2 slip_pos", bus.slip_pos, 1);

    // scenario 3: seven slips
    do_reset(8'hE1);
    run_until_aligned("s3", 120);
    chk("s3 latency", cyc - t_start, 50);
    chk("s3 slips", slip_cnt, 7);
    chk("s3 slip_pos", bus.slip_pos, 7);
    chk("s3 min gap", min_gap, 6);

    // scenario 3b: one extra slip wraps slip_pos
    do_reset(8'hE1);
    skip_next_slip = 1'b1;
    run_until_aligned("s3b", 120);
    chk("s3b latency", cyc - t_start, 56);
    chk("s3b slips", slip_cnt, 8);
    chk("s3b slip_pos wrap", bus.slip_pos, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
